// File: rtl/afpm_mul_round.sv
`default_nettype none
// ============================================================================
// Module      : afpm_mul_round
// Description : Two-stage normalize / round-to-nearest-even / pack stage for
//               the single-precision multiply path. Consumes the 64-bit
//               significand product plus operand signs and exponents, handles
//               special operands and emits an IEEE-754 binary32 result with
//               sticky exception flags {invalid, overflow, underflow, inexact}.
// Revision    : 1.0 - initial release
// ============================================================================
module afpm_mul_round #(
   parameter int          BIAS      = 127,
   parameter logic [31:0] NAN_VALUE = 32'h7FFFFFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign_a,
   input  logic        in_sign_b,
   input  logic [7:0]  in_exp_a,
   input  logic [7:0]  in_exp_b,
   input  logic        in_frac_nz_a,
   input  logic        in_frac_nz_b,
   input  logic [63:0] in_sig_product,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   input  logic        flag_clear,
   output logic [3:0]  flags
);

   localparam logic [9:0] c_bias     = 10'(BIAS);
   localparam logic [9:0] c_exp_max  = 10'd255;
   localparam int         c_f_inv    = 3;
   localparam int         c_f_ovf    = 2;
   localparam int         c_f_unf    = 1;
   localparam int         c_f_inx    = 0;

   // ---------------------------------------------------------------------
   // Pipeline control
   // ---------------------------------------------------------------------
   logic        r_s1_valid;
   logic        r_s2_valid;
   logic        w_s2_adv;
   logic        w_s1_adv;

   // Stage 1 state
   logic        r_s1_sign;
   logic [47:0] r_s1_prod;
   logic        r_s1_nan;
   logic        r_s1_inf;
   logic        r_s1_zero;
   logic [9:0]  r_s1_exp;

   // Stage 2 state
   logic [31:0] r_s2_result;
   logic [3:0]  r_s2_flags;
   logic [3:0]  r_flags;

   // Stage-1 classification
   logic        w_nan;
   logic        w_inf;
   logic        w_zero;
   logic [9:0]  w_exp_sum;

   // Stage-2 normalize / round / pack
   logic [22:0] w_frac;
   logic        w_guard;
   logic        w_sticky;
   logic        w_inc;
   logic [23:0] w_frac_sum;
   logic [9:0]  w_exp_rnd;
   logic        w_exp_le0;
   logic        w_exp_ovf;
   logic [31:0] w_result;
   logic [3:0]  w_flags;

   // A stage may move when its downstream slot is empty or being drained;
   // in_ready therefore depends combinationally on out_ready.
   always_comb begin
      w_s2_adv = !r_s2_valid || out_ready;
      w_s1_adv = !r_s1_valid || w_s2_adv;
   end

   assign in_ready   = w_s1_adv;
   assign out_valid  = r_s2_valid;
   assign out_result = r_s2_result;
   assign flags      = r_flags;

   // Operand classification and biased exponent sum (10-bit two's complement)
   always_comb begin
      w_nan  = ((in_exp_a == 8'hFF) && in_frac_nz_a) ||
               ((in_exp_b == 8'hFF) && in_frac_nz_b);
      w_inf  = ((in_exp_a == 8'hFF) && !in_frac_nz_a) ||
               ((in_exp_b == 8'hFF) && !in_frac_nz_b);
      // Subnormals (exponent 0) are flushed to zero
      w_zero = (in_exp_a == 8'h00) || (in_exp_b == 8'h00);
      w_exp_sum = {2'b00, in_exp_a} + {2'b00, in_exp_b} - c_bias
                + {9'd0, in_sig_product[47]};
   end

   // Stage 1 register: captures sign, product and operand class
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_prod  <= 48'd0;
         r_s1_nan   <= 1'b0;
         r_s1_inf   <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_exp   <= 10'd0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sign <= in_sign_a ^ in_sign_b;
            r_s1_prod <= in_sig_product[47:0];
            r_s1_nan  <= w_nan;
            r_s1_inf  <= w_inf;
            r_s1_zero <= w_zero;
            r_s1_exp  <= w_exp_sum;
         end
      end
   end

   // Normalize on the weight-2 bit, round to nearest-even, then pack by priority
   always_comb begin
      w_frac     = 23'd0;
      w_guard    = 1'b0;
      w_sticky   = 1'b0;
      w_result   = 32'd0;
      w_flags    = 4'd0;
      if (r_s1_prod[47]) begin
         w_frac   = r_s1_prod[46:24];
         w_guard  = r_s1_prod[23];
         w_sticky = |r_s1_prod[22:0];
      end else begin
         w_frac   = r_s1_prod[45:23];
         w_guard  = r_s1_prod[22];
         w_sticky = |r_s1_prod[21:0];
      end
      w_inc      = w_guard && (w_sticky || w_frac[0]);
      w_frac_sum = {1'b0, w_frac} + {23'd0, w_inc};
      // A carry out of the fraction leaves the fraction field at zero
      w_exp_rnd  = r_s1_exp + {9'd0, w_frac_sum[23]};
      w_exp_le0  = r_s1_exp[9] || (r_s1_exp == 10'd0);
      w_exp_ovf  = !w_exp_rnd[9] && (w_exp_rnd >= c_exp_max);

      if (r_s1_nan || (r_s1_inf && r_s1_zero)) begin
         w_result         = NAN_VALUE;
         w_flags[c_f_inv] = 1'b1;
      end else if (r_s1_inf) begin
         w_result = {r_s1_sign, 8'hFF, 23'd0};
      end else if (r_s1_zero) begin
         w_result = {r_s1_sign, 31'd0};
      end else if (w_exp_le0) begin
         w_result         = {r_s1_sign, 31'd0};
         w_flags[c_f_unf] = 1'b1;
         w_flags[c_f_inx] = 1'b1;
      end else if (w_exp_ovf) begin
         w_result         = {r_s1_sign, 8'hFF, 23'd0};
         w_flags[c_f_ovf] = 1'b1;
         w_flags[c_f_inx] = 1'b1;
      end else begin
         w_result         = {r_s1_sign, w_exp_rnd[7:0], w_frac_sum[22:0]};
         w_flags[c_f_inx] = w_guard || w_sticky;
      end
   end

   // Stage 2 register: result is held while the consumer stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= 32'd0;
         r_s2_flags  <= 4'd0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result <= w_result;
            r_s2_flags  <= w_flags;
         end
      end
   end

   // Sticky flags: accumulate on accept; a clear coinciding with an accept
   // keeps only the accepted beat's flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_flags <= 4'd0;
      end else if (r_s2_valid && out_ready) begin
         r_flags <= flag_clear ? r_s2_flags : (r_flags | r_s2_flags);
      end else if (flag_clear) begin
         r_flags <= 4'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_afpm_mul_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_afpm_mul_round
// Description : Scoreboard bench for afpm_mul_round: directed and random beats,
//               back-pressure, flag clearing and asynchronous reset mid-stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afpm_mul_round;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  flg;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sign_a = 1'b0;
   logic        in_sign_b = 1'b0;
   logic [7:0]  in_exp_a = 8'd0;
   logic [7:0]  in_exp_b = 8'd0;
   logic        in_frac_nz_a = 1'b0;
   logic        in_frac_nz_b = 1'b0;
   logic [63:0] in_sig_product = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        flag_clear = 1'b0;
   logic [3:0]  flags;

   exp_t        scb[$];
   int          checks = 0;
   int          failures = 0;
   logic [3:0]  model_flags = 4'd0;
   bit          rand_en = 1'b0;

   always #5 clk = ~clk;

   afpm_mul_round #(.BIAS(127), .NAN_VALUE(32'h7FFFFFFF)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign_a(in_sign_a), .in_sign_b(in_sign_b),
      .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
      .in_frac_nz_a(in_frac_nz_a), .in_frac_nz_b(in_frac_nz_b),
      .in_sig_product(in_sig_product),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .flag_clear(flag_clear), .flags(flags)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: integer arithmetic on the product value, rounding via remainder
   function automatic exp_t ref_model(input logic sa, input logic sb, input logic [7:0] ea,
                                      input logic [7:0] eb, input logic nza, input logic nzb,
                                      input logic [63:0] p);
      longint unsigned m, kept, rem, half;
      int  sh, e, e2, f, f2;
      bit  hi, up, nan, inf, zero;
      logic s;
      exp_t r;
      m    = p & 64'h0000_FFFF_FFFF_FFFF;
      hi   = (m >= (64'd1 << 47));
      sh   = hi ? 24 : 23;
      kept = m >> sh;
      rem  = m - (kept << sh);
      half = 64'd1 << (sh - 1);
      f    = int'(kept % (64'd1 << 23));
      e    = int'(ea) + int'(eb) - 127 + (hi ? 1 : 0);
      up   = (rem > half) || ((rem == half) && ((f % 2) == 1));
      f2   = f + (up ? 1 : 0);
      e2   = e;
      if (f2 == (1 << 23)) begin
         f2 = 0;
         e2 = e + 1;
      end
      s    = sa ^ sb;
      nan  = ((ea == 8'd255) && nza) || ((eb == 8'd255) && nzb);
      inf  = ((ea == 8'd255) && !nza) || ((eb == 8'd255) && !nzb);
      zero = (ea == 8'd0) || (eb == 8'd0);
      if (nan || (inf && zero)) begin
         r.res = 32'h7FFFFFFF; r.flg = 4'b1000;
      end else if (inf) begin
         r.res = {s, 8'hFF, 23'd0}; r.flg = 4'b0000;
      end else if (zero) begin
         r.res = {s, 31'd0}; r.flg = 4'b0000;
      end else if (e <= 0) begin
         r.res = {s, 31'd0}; r.flg = 4'b0011;
      end else if (e2 >= 255) begin
         r.res = {s, 8'hFF, 23'd0}; r.flg = 4'b0101;
      end else begin
         r.res = {s, 8'(e2), 23'(f2)}; r.flg = {3'b000, rem != 0};
      end
      return r;
   endfunction

   // Drive one beat, wait (bounded) for acceptance and record the expectation
   task automatic send(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                       input logic nza, input logic nzb, input logic [63:0] p, input exp_t e);
      int n;
      in_sign_a = sa; in_sign_b = sb; in_exp_a = ea; in_exp_b = eb;
      in_frac_nz_a = nza; in_frac_nz_b = nzb; in_sig_product = p;
      in_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         failures++;
         checks++;
         $display("FAIL in_ready_timeout actual=0 required=1");
      end else begin
         scb.push_back(e);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_model(input logic sa, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                             input logic nza, input logic nzb, input logic [63:0] p);
      send(sa, sb, ea, eb, nza, nzb, p, ref_model(sa, sb, ea, eb, nza, nzb, p));
   endtask

   function automatic logic [7:0] rand_exp();
      int k;
      k = $urandom_range(0, 19);
      if (k == 0) return 8'd0;
      if (k == 1) return 8'd255;
      if (k < 5)  return 8'($urandom_range(1, 40));
      if (k < 8)  return 8'($urandom_range(200, 254));
      return 8'($urandom_range(100, 160));
   endfunction

   task automatic send_rand();
      logic [63:0] p;
      int mode;
      p = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      if (mode == 0 || mode == 1) p[47] = 1'b1;
      if (mode == 2) begin p[47] = 1'b0; p[46] = 1'b1; end
      if (mode == 3) begin p[47] = 1'b1; p[23] = 1'b1; p[22:0] = 23'd0; end
      if (mode == 4) begin p[47:46] = 2'b01; p[22] = 1'b1; p[21:0] = 22'd0; end
      if (mode == 5) begin p[47] = 1'b1; p[46:23] = 24'hFFFFFF; end
      send_model(1'($urandom), 1'($urandom), rand_exp(), rand_exp(),
                 1'($urandom), 1'($urandom), p);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (scb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (scb.size() != 0) begin
         failures++;
         checks++;
         $display("FAIL drain_timeout actual=%0d required=0", scb.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: verify sticky flags each cycle, pop and compare on every accept
   always @(negedge clk) begin
      if (reset_n) begin
         check("flags", 64'(flags), 64'(model_flags));
         if (out_valid && out_ready) begin
            if (scb.size() == 0) begin
               check("unexpected_output", 64'(out_result), 64'hDEAD_BEEF_0000_0000);
            end else begin
               exp_t e;
               e = scb.pop_front();
               check("result", 64'(out_result), 64'(e.res));
               model_flags = flag_clear ? e.flg : (model_flags | e.flg);
            end
         end else if (flag_clear) begin
            model_flags = 4'd0;
         end
      end
   end

   // Random back-pressure and flag clearing during the random phase
   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         out_ready  = ($urandom_range(0, 3) != 0);
         flag_clear = ($urandom_range(0, 19) == 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      #1 reset_n = 1'b0;
      #2;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", 64'(out_result), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed: 1.5 x 1.5 with explicit two-cycle latency
      e.res = 32'h40100000; e.flg = 4'b0000;
      send(1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'h0000_9000_0000_0000, e);
      check("lat_not_yet", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_valid", 64'(out_valid), 64'd1);
      check("lat_result", 64'(out_result), 64'h40100000);
      drain();
      check("flags_after_1p5", 64'(flags), 64'd0);

      // Directed: tie rounds to even (odd lsb increments)
      e.res = 32'h40000002; e.flg = 4'b0001;
      send(1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'h0000_8000_0180_0000, e);
      // Directed: overflow
      e.res = 32'h7F800000; e.flg = 4'b0101;
      send(1'b0, 1'b0, 8'd254, 8'd254, 1'b0, 1'b0, 64'h0000_4000_0000_0000, e);
      // Directed: Inf x Zero is invalid
      e.res = 32'h7FFFFFFF; e.flg = 4'b1000;
      send(1'b0, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 64'h0000_8000_0000_0000, e);
      drain();
      check("flags_sticky", 64'(flags), 64'hD);
      flag_clear = 1'b1;
      @(posedge clk);
      #1 flag_clear = 1'b0;
      check("flags_cleared", 64'(flags), 64'd0);

      // Directed: underflow with negative sign
      e.res = 32'h80000000; e.flg = 4'b0011;
      send(1'b1, 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, 64'h0000_4000_0000_0000, e);
      drain();
      check("flags_underflow", 64'(flags), 64'h3);

      // Back-pressure: four beats against a stalled consumer
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++) send_rand();
         end
         begin
            repeat (5) @(posedge clk);
            #2;
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_hold_a", 64'(out_result), 64'(scb[0].res));
            @(posedge clk);
            #2;
            check("bp_hold_b", 64'(out_result), 64'(scb[0].res));
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset while both stages hold beats
      out_ready = 1'b0;
      send_rand();
      send_rand();
      check("rs_s2_full", 64'(out_valid), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rs_out_valid_async", 64'(out_valid), 64'd0);
      check("rs_out_result", 64'(out_result), 64'd0);
      check("rs_in_ready", 64'(in_ready), 64'd1);
      scb.delete();
      model_flags = 4'd0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rs_no_stale", 64'(out_valid), 64'd0);
      e.res = 32'h40100000; e.flg = 4'b0000;
      send(1'b0, 1'b0, 8'd127, 8'd127, 1'b0, 1'b0, 64'h0000_9000_0000_0000, e);
      send_model(1'b1, 1'b1, 8'd130, 8'd120, 1'b0, 1'b0, 64'h0000_A5A5_1234_5678);
      drain();

      // Random stream with random stalls and flag clears
      rand_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send_rand();
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_en = 1'b0;
      @(posedge clk);
      #2;
      out_ready  = 1'b1;
      flag_clear = 1'b0;
      drain();
      check("scoreboard_empty", 64'(scb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
